// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core memory path.
//   word_t      : one machine word (address, store data, load data)
//   ramstate_t  : status reported by the unified RAM model
//   arb_state_t : states of the instruction/data memory arbiter
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_XFER = 2'b01,
    D_XFER = 2'b10,
    HALTED = 2'b11
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported unified RAM between instruction fetch
// and data memory. One transfer at a time; address/store/op are latched at
// grant so the RAM sees stable values while the requesters are ignored.
// Data wins arbitration unless fetch has been passed over STARVE_LIMIT times.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   iREN, iaddr        instruction read request and address
//   dREN, dWEN         data read / write request (both high = write)
//   daddr, dstore      data address and store value
//   halt               core halted: drain the current transfer, then stop
//   iwait, dwait       1 until the matching transfer completes
//   iload, dload       load data, valid only in the completion cycle
//   ramREN, ramWEN     RAM enables (mutually exclusive, only during a transfer)
//   ramaddr, ramstore  latched address / store data towards the RAM
//   ramload, ramstate  RAM read data and status
//   halted             arbiter has stopped (until reset)
//   ram_err            sticky: RAM reported ERROR
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic              halt,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              halted,
  output logic              ram_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t        state, state_nxt;
  logic [WORD_W-1:0] addr_q, addr_nxt;
  logic [WORD_W-1:0] store_q, store_nxt;
  logic              op_wr_q, op_wr_nxt;
  logic [3:0]        cnt_q, cnt_nxt;
  logic              err_q, err_nxt;
  logic              dreq;
  logic              i_starved;

  assign dreq      = dREN | dWEN;
  // Fetch has waited through LIMIT data grants: it takes the next slot.
  assign i_starved = iREN && (cnt_q == LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      store_q <= store_nxt;
      op_wr_q <= op_wr_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    store_nxt = store_q;
    op_wr_nxt = op_wr_q;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;

    case (state)
      IDLE: begin
        if (dreq && !i_starved) begin
          state_nxt = D_XFER;
          addr_nxt  = daddr;
          store_nxt = dstore;
          op_wr_nxt = dWEN;
          if (iREN)
            cnt_nxt = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 4'd1;
          else
            cnt_nxt = '0;
        end else if (iREN && !halt) begin
          state_nxt = I_XFER;
          addr_nxt  = iaddr;
          store_nxt = '0;
          op_wr_nxt = 1'b0;
          cnt_nxt   = '0;
        end else if (halt && !dreq) begin
          state_nxt = HALTED;
        end
      end

      I_XFER: begin
        ramREN = 1'b1;
        if (ramstate == ACCESS) begin
          iwait     = 1'b0;
          iload     = ramload;
          state_nxt = IDLE;
        end else if (ramstate == ERROR) begin
          // Wait stays high; the still-pending request is re-arbitrated.
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      D_XFER: begin
        ramREN = !op_wr_q;
        ramWEN = op_wr_q;
        if (ramstate == ACCESS) begin
          dwait     = 1'b0;
          dload     = op_wr_q ? '0 : ramload;
          state_nxt = IDLE;
        end else if (ramstate == ERROR) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      HALTED: begin
        state_nxt = HALTED;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign halted   = (state == HALTED);
  assign ram_err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM answers reads with a
// fixed function of the address; expected transfers are queued when stimulus
// is applied and checked in order at each RAM completion.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam logic [1:0] K_I  = 2'd0;
  localparam logic [1:0] K_DR = 2'd1;
  localparam logic [1:0] K_DW = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, halted, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [1:0]  mon_kind;
  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;

  mem_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .halt(halt),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .halted(halted), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C01_0004 : ((a ^ 32'h5A5A_0000) + 32'h1);
  endfunction

  assign ramload = mem_fn(ramaddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] s);
    exp_t e;
    e.kind  = kind;
    e.addr  = a;
    e.store = s;
    e.load  = (kind == K_DW) ? 32'h0 : mem_fn(a);
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic half();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_done(input int tgt);
    int budget;
    budget = 40;
    while (done_cnt < tgt && budget > 0) begin
      half();
      budget--;
    end
    if (done_cnt < tgt) chk("done_timeout", 32'(done_cnt), 32'(tgt));
  endtask

  // Completion monitor: a transfer ends when an enable is up and RAM says ACCESS.
  always @(negedge CLK) begin
    if (nRST) begin
      chk("excl_en", {31'b0, ramREN & ramWEN}, 32'h0);
      if ((ramREN || ramWEN) && ramstate == ACCESS) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'(sb.size()), 32'h1);
        end else begin
          mon_e    = sb.pop_front();
          mon_kind = !iwait ? K_I : (ramWEN ? K_DW : K_DR);
          chk("kind", {30'b0, mon_kind}, {30'b0, mon_e.kind});
          chk("ramaddr", ramaddr, mon_e.addr);
          if (mon_e.kind == K_DW) chk("ramstore", ramstore, mon_e.store);
          chk("iload", iload, (mon_e.kind == K_I) ? mon_e.load : 32'h0);
          chk("dload", dload, (mon_e.kind == K_DR) ? mon_e.load : 32'h0);
          chk("iwait_done", {31'b0, iwait}, (mon_e.kind == K_I) ? 32'h0 : 32'h1);
          chk("dwait_done", {31'b0, dwait}, (mon_e.kind == K_I) ? 32'h1 : 32'h0);
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramstate = ACCESS;

    // Reset values, before any clock edge.
    #3;
    chk("rst_ramREN", {31'b0, ramREN}, 32'h0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_iwait", {31'b0, iwait}, 32'h1);
    chk("rst_dwait", {31'b0, dwait}, 32'h1);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_ram_err", {31'b0, ram_err}, 32'h0);
    half();
    half();
    nRST = 1'b1;

    // Single fetch, RAM answers at once.
    cyc();
    iREN = 1'b1; iaddr = 32'h40;
    push_exp(K_I, 32'h40, 32'h0);
    cyc();
    @(negedge CLK); #1;
    chk("t1_ramREN", {31'b0, ramREN}, 32'h1);
    chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait", {31'b0, iwait}, 32'h0);
    chk("t1_iload", iload, 32'h8C01_0004);
    iREN = 1'b0;
    cyc();
    @(negedge CLK); #1;
    chk("t1_idle_ramREN", {31'b0, ramREN}, 32'h0);
    chk("t1_idle_iwait", {31'b0, iwait}, 32'h1);

    // Fetch and store together: store first, fetch after the bubble.
    cyc();
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    push_exp(K_DW, 32'h100, 32'hDEAD_BEEF);
    push_exp(K_I, 32'h44, 32'h0);
    wait_done(done_cnt + 1);
    dWEN = 1'b0;
    wait_done(done_cnt + 1);
    iREN = 1'b0;

    // Starvation bound: four data grants, then one fetch, repeated.
    cyc();
    iREN = 1'b1; iaddr = 32'h48;
    dREN = 1'b1; daddr = 32'h104;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_exp(K_DR, 32'h104, 32'h0);
      push_exp(K_I, 32'h48, 32'h0);
    end
    wait_done(done_cnt + 10);
    iREN = 1'b0; dREN = 1'b0;

    // Busy RAM: address held even though daddr moves.
    cyc();
    dREN = 1'b1; daddr = 32'h108; ramstate = BUSY;
    push_exp(K_DR, 32'h108, 32'h0);
    cyc();
    dREN = 1'b0; daddr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      chk("busy_dwait", {31'b0, dwait}, 32'h1);
      chk("busy_ramaddr", ramaddr, 32'h108);
      chk("busy_ramREN", {31'b0, ramREN}, 32'h1);
      if (k < 2) cyc();
    end
    cyc();
    ramstate = ACCESS;
    @(negedge CLK); #1;
    chk("busy_done_dwait", {31'b0, dwait}, 32'h0);

    // RAM error on fetch, then successful retry.
    cyc();
    iREN = 1'b1; iaddr = 32'h4C; ramstate = ERROR;
    push_exp(K_I, 32'h4C, 32'h0);
    cyc();
    @(negedge CLK); #1;
    chk("err_iwait", {31'b0, iwait}, 32'h1);
    chk("err_ramREN", {31'b0, ramREN}, 32'h1);
    cyc();
    ramstate = ACCESS;
    @(negedge CLK); #1;
    chk("err_sticky", {31'b0, ram_err}, 32'h1);
    chk("err_idle_ramREN", {31'b0, ramREN}, 32'h0);
    chk("err_idle_iwait", {31'b0, iwait}, 32'h1);
    wait_done(done_cnt + 1);
    iREN = 1'b0;
    chk("err_still_set", {31'b0, ram_err}, 32'h1);

    // Halt with a data read pending: the read drains, then the arbiter stops.
    cyc();
    dREN = 1'b1; daddr = 32'h10C; halt = 1'b1;
    push_exp(K_DR, 32'h10C, 32'h0);
    wait_done(done_cnt + 1);
    dREN = 1'b0; iREN = 1'b1; iaddr = 32'h50;
    half();
    chk("halt_bubble_ramREN", {31'b0, ramREN}, 32'h0);
    half();
    chk("halted", {31'b0, halted}, 32'h1);
    chk("halted_ramREN", {31'b0, ramREN}, 32'h0);
    chk("halted_iwait", {31'b0, iwait}, 32'h1);
    chk("halted_dwait", {31'b0, dwait}, 32'h1);
    halt = 1'b0; dREN = 1'b1;
    for (int k = 0; k < 3; k++) half();
    chk("halted_absorb", {31'b0, halted}, 32'h1);
    chk("halted_ramREN2", {31'b0, ramREN}, 32'h0);
    chk("halted_ramWEN2", {31'b0, ramWEN}, 32'h0);

    // Reset leaves HALTED and clears the sticky flags without a clock edge.
    cyc();
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0;
    #1;
    chk("rst2_halted", {31'b0, halted}, 32'h0);
    chk("rst2_ram_err", {31'b0, ram_err}, 32'h0);
    half();
    cyc();
    nRST = 1'b1;

    // Reset in the middle of a stalled store.
    cyc();
    dWEN = 1'b1; daddr = 32'h110; dstore = 32'hCAFE_F00D; ramstate = BUSY;
    cyc();
    @(negedge CLK); #1;
    chk("mid_ramWEN", {31'b0, ramWEN}, 32'h1);
    chk("mid_ramstore", ramstore, 32'hCAFE_F00D);
    nRST = 1'b0;
    #1;
    chk("mid_rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("mid_rst_ramREN", {31'b0, ramREN}, 32'h0);
    chk("mid_rst_ramaddr", ramaddr, 32'h0);
    chk("mid_rst_ramstore", ramstore, 32'h0);
    chk("mid_rst_dwait", {31'b0, dwait}, 32'h1);
    chk("mid_rst_iwait", {31'b0, iwait}, 32'h1);
    chk("mid_rst_dload", dload, 32'h0);
    dWEN = 1'b0;
    cyc();
    nRST = 1'b1;
    ramstate = ACCESS;
    half();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-ported unified RAM between the instruction-fetch requester and the data-memory requester of the MIPS core.
- Sits between the datapath (iREN/dREN/dWEN driven from fetch and from the control unit's MemRead/MemWrite) and the RAM model.
- Serialises accesses, latches address and store data at grant, and returns wait/load to each side.
- Gives data priority with an anti-starvation bound for fetch, and handles the HALT drain.

Parameters:
- WORD_W, 32, width of address, store and load words (matches word_t).
- STARVE_LIMIT, 4, number of consecutive data grants allowed while a fetch is pending; the next grant then goes to fetch. Range 1..15.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  WORD_W  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- halt  in  1  core halted; drain and stop
- iwait  out  1  fetch not complete
- dwait  out  1  data access not complete
- iload  out  WORD_W  fetched word
- dload  out  WORD_W  loaded data word
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: FREE / BUSY / ACCESS / ERROR
- halted  out  1  sticky: arbiter stopped
- ram_err  out  1  sticky: ERROR status seen

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low. Reset may assert at any time, including mid-transfer, and on reset:
  - state goes to IDLE;
  - latched addr, store and op registers clear to 0;
  - starvation counter clears to 0;
  - halted and ram_err clear to 0.
- Outputs while in reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
- States: IDLE, I_XFER, D_XFER, HALTED.
- IDLE arbitration, registered. Let dreq = dREN|dWEN.
  - if dreq and not (iREN and cnt==STARVE_LIMIT): go to D_XFER; latch daddr, dstore, op (write if dWEN, else read).
  - else if iREN and not halt: go to I_XFER; latch iaddr, op=read.
  - else if halt and not dreq: go to HALTED.
  - else stay in IDLE.
  - dREN and dWEN both high: treated as a write.
- Starvation counter (4 bits), updated only on a grant edge:
  - D grant with iREN high: cnt+1, saturating at STARVE_LIMIT.
  - any I grant, or D grant with iREN low: cnt=0.
- XFER states:
  - ramaddr/ramstore driven from the latched registers.
  - I_XFER: ramREN=1.
  - D_XFER: ramREN or ramWEN from the latched op.
  - Requester inputs are ignored until completion.
- Completion: ramstate==ACCESS in XFER.
  - In that cycle the matching wait=0, combinationally.
  - iload or dload = ramload in that cycle; 0 otherwise. dload is also 0 on writes.
  - Next state IDLE. There is no chaining: one idle bubble follows every transfer, because the requester's request is stale during its completion cycle.
- BUSY or FREE in XFER: hold state and all RAM outputs; wait stays 1.
- ERROR in XFER: set ram_err (sticky), return to IDLE with wait still 1. The request is re-arbitrated as a retry.
- Minimum latency: request seen in IDLE at cycle 0 → enables asserted at cycle 1 → wait low at cycle 1 if RAM returns ACCESS immediately.
- HALTED: all enables 0, both waits 1, halted=1. Absorbing until reset.
- halt during XFER: the current transfer completes normally; halt takes effect at the next IDLE.
- Enables are never asserted outside XFER. ramREN and ramWEN are never both 1.

Decomposition:
- cpu_types_pkg: ramstate_t (FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11), word_t, and arb_state_t (IDLE, I_XFER, D_XFER, HALTED).
- No sub-module: the FSM, latch registers and counter fit in a single module.

Test Plan:
- Only iREN=1, iaddr=0x40, RAM returns ACCESS on first enable cycle with ramload=0x8C010004 → ramREN=1, ramaddr=0x40 at cycle 1; iwait=0, iload=0x8C010004 at cycle 1; back to IDLE at cycle 2.
- iREN and dWEN both high, daddr=0x100, dstore=0xDEADBEEF → D granted first (ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF); after the bubble, I granted; cnt resets to 0.
- iREN held high, dREN held high continuously, STARVE_LIMIT=4, ACCESS each cycle → grant order D,D,D,D,I,D…; exactly one I grant per five transfers.
- D_XFER with ramstate BUSY for 3 cycles then ACCESS → dwait=1 for 3 cycles, ramaddr stable even if daddr is changed to 0x200 mid-wait; dwait=0 on the 4th cycle.
- ramstate=ERROR during I_XFER → ram_err=1, return to IDLE, iwait stays 1; retry succeeds on ACCESS; ram_err stays 1.
- halt=1 with dREN pending → D transfer completes, then HALTED: halted=1 and no enables despite iREN=1. nRST pulse mid-D_XFER → outputs return to reset values immediately, without waiting for a CLK edge.
